// File: rtl/hdu_scoreboard_ctrl_pkg.sv
// Shared types and encodings for the RV32I hazard detection unit.
// The control triplet is always ordered {stall_n, flush_id_ex, flush_if_id_ex_mem}.
package hdu_scoreboard_ctrl_pkg;

  typedef struct packed {
    logic stall_n;
    logic flush_id_ex;
    logic flush_if_id_ex_mem;
    logic freeze;
  } hdu_ctrl_t;

  localparam logic [2:0] HDU_NORMAL = 3'b100;
  localparam logic [2:0] HDU_BUBBLE = 3'b010;
  localparam logic [2:0] HDU_FLUSH  = 3'b111;

endpackage

// File: rtl/hdu_scoreboard_ctrl_busy_sb.sv
// Per-register busy scoreboard for variable-latency results.
// Entry 0 is never set and always reads as idle. A set and a clear of the same entry in one cycle leave it set.
module hdu_busy_sb #(
  parameter int AW = 5,
  parameter int N  = 2**AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_a_idx,
  input  logic [AW-1:0] rd_b_idx,
  input  logic [AW-1:0] rd_w_idx,
  output logic          rd_a,
  output logic          rd_b,
  output logic          rd_w,
  output logic [N-1:0]  busy_vec
);

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;

  // Next busy state: the clear is applied first so that a set to the same entry overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_idx] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (set_en) begin
      busy_d[set_idx] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Busy register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rd_a     = (rd_a_idx != '0) && busy_q[rd_a_idx];
  assign rd_b     = (rd_b_idx != '0) && busy_q[rd_b_idx];
  assign rd_w     = (rd_w_idx != '0) && busy_q[rd_w_idx];
  assign busy_vec = busy_q;

endmodule

// File: rtl/hdu_scoreboard_ctrl.sv
// Hazard detection unit in ID: load-use bubbles, branch/jump flush, busy scoreboard and memory freeze.
// Outputs are combinational from inputs and registered state.
module hdu_scoreboard_ctrl
  import hdu_scoreboard_ctrl_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NUM_REGS      = 2**RF_ADDR_WIDTH,
  parameter int LOAD_BUBBLES  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [RF_ADDR_WIDTH-1:0] ifid_rs1,
  input  logic [RF_ADDR_WIDTH-1:0] ifid_rs2,
  input  logic [RF_ADDR_WIDTH-1:0] ifid_rd,
  input  logic                     ifid_reg_write,
  input  logic                     ifid_mem_write,
  input  logic                     ifid_long_op,
  input  logic [RF_ADDR_WIDTH-1:0] idex_rd,
  input  logic                     idex_mem_read,
  input  logic                     branch_or_jump,
  input  logic                     mem_busy,
  input  logic                     long_wb_valid,
  input  logic [RF_ADDR_WIDTH-1:0] long_wb_rd,
  output logic                     stall_n,
  output logic                     flush_id_ex,
  output logic                     flush_if_id_ex_mem,
  output logic                     freeze,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam int BW = $clog2(LOAD_BUBBLES + 1);
  localparam logic [BW-1:0] BUB_ONE    = BW'(1);
  localparam logic [BW-1:0] BUB_RELOAD = BW'(LOAD_BUBBLES - 1);

  logic [BW-1:0] bub_cnt_q;
  logic [BW-1:0] bub_cnt_d;
  hdu_ctrl_t     ctrl_s;
  logic          load_use_s;
  logic          sb_hazard_s;
  logic          issue_s;
  logic          busy_rs1_s;
  logic          busy_rs2_s;
  logic          busy_rd_s;

  // Stores forward rs2 from MEM, so a store's data operand does not need a load-use bubble.
  assign load_use_s  = idex_mem_read && (idex_rd != '0) && !ifid_mem_write &&
                       ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  assign sb_hazard_s = busy_rs1_s || busy_rs2_s || (ifid_reg_write && busy_rd_s);

  // Priority resolution of pipeline control and bubble counter next state.
  always_comb begin
    ctrl_s    = '{stall_n: 1'b1, flush_id_ex: 1'b0, flush_if_id_ex_mem: 1'b0, freeze: 1'b0};
    bub_cnt_d = bub_cnt_q;
    if (!enable) begin
      {ctrl_s.stall_n, ctrl_s.flush_id_ex, ctrl_s.flush_if_id_ex_mem} = HDU_NORMAL;
      bub_cnt_d = '0;
    end else if (mem_busy) begin
      ctrl_s.stall_n = 1'b0;
      ctrl_s.freeze  = 1'b1;
    end else if (branch_or_jump) begin
      {ctrl_s.stall_n, ctrl_s.flush_id_ex, ctrl_s.flush_if_id_ex_mem} = HDU_FLUSH;
      bub_cnt_d = '0;
    end else if (bub_cnt_q != '0) begin
      {ctrl_s.stall_n, ctrl_s.flush_id_ex, ctrl_s.flush_if_id_ex_mem} = HDU_BUBBLE;
      bub_cnt_d = bub_cnt_q - BUB_ONE;
    end else if (load_use_s) begin
      {ctrl_s.stall_n, ctrl_s.flush_id_ex, ctrl_s.flush_if_id_ex_mem} = HDU_BUBBLE;
      bub_cnt_d = BUB_RELOAD;
    end else if (sb_hazard_s) begin
      {ctrl_s.stall_n, ctrl_s.flush_id_ex, ctrl_s.flush_if_id_ex_mem} = HDU_BUBBLE;
    end else begin
      {ctrl_s.stall_n, ctrl_s.flush_id_ex, ctrl_s.flush_if_id_ex_mem} = HDU_NORMAL;
    end
  end

  // Bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_cnt_q <= '0;
    end else begin
      bub_cnt_q <= bub_cnt_d;
    end
  end

  assign issue_s = enable && ifid_long_op && ifid_reg_write && (ifid_rd != '0) &&
                   ({ctrl_s.stall_n, ctrl_s.flush_id_ex, ctrl_s.flush_if_id_ex_mem} == HDU_NORMAL) &&
                   !ctrl_s.freeze;

  hdu_busy_sb #(
    .AW (RF_ADDR_WIDTH),
    .N  (NUM_REGS)
  ) u_busy_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_s),
    .set_idx  (ifid_rd),
    .clr_en   (long_wb_valid),
    .clr_idx  (long_wb_rd),
    .rd_a_idx (ifid_rs1),
    .rd_b_idx (ifid_rs2),
    .rd_w_idx (ifid_rd),
    .rd_a     (busy_rs1_s),
    .rd_b     (busy_rs2_s),
    .rd_w     (busy_rd_s),
    .busy_vec (busy_vec)
  );

  assign stall_n            = ctrl_s.stall_n;
  assign flush_id_ex        = ctrl_s.flush_id_ex;
  assign flush_if_id_ex_mem = ctrl_s.flush_if_id_ex_mem;
  assign freeze             = ctrl_s.freeze;

endmodule

// File: tb/tb_hdu_scoreboard_ctrl.sv
// Self-checking bench for hdu_scoreboard_ctrl with LOAD_BUBBLES=2: a cycle table whose expectations
// are queued at drive time and compared on the falling edge, plus a hand-written async-reset sequence.
module tb_hdu_scoreboard_ctrl;

  typedef struct {
    string       nm;
    logic        en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        lop;
    logic [4:0]  exrd;
    logic        exmr;
    logic        boj;
    logic        mb;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_busy;
  } vec_t;

  typedef struct {
    string       nm;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [4:0]  ifid_rs1, ifid_rs2, ifid_rd, idex_rd, long_wb_rd;
  logic        ifid_reg_write, ifid_mem_write, ifid_long_op;
  logic        idex_mem_read, branch_or_jump, mem_busy, long_wb_valid;
  logic        stall_n, flush_id_ex, flush_if_id_ex_mem, freeze;
  logic [31:0] busy_vec;

  int   checks   = 0;
  int   failures = 0;
  vec_t vt[$];
  exp_t sbq[$];

  hdu_scoreboard_ctrl #(
    .RF_ADDR_WIDTH (5),
    .NUM_REGS      (32),
    .LOAD_BUBBLES  (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .ifid_rs1           (ifid_rs1),
    .ifid_rs2           (ifid_rs2),
    .ifid_rd            (ifid_rd),
    .ifid_reg_write     (ifid_reg_write),
    .ifid_mem_write     (ifid_mem_write),
    .ifid_long_op       (ifid_long_op),
    .idex_rd            (idex_rd),
    .idex_mem_read      (idex_mem_read),
    .branch_or_jump     (branch_or_jump),
    .mem_busy           (mem_busy),
    .long_wb_valid      (long_wb_valid),
    .long_wb_rd         (long_wb_rd),
    .stall_n            (stall_n),
    .flush_id_ex        (flush_id_ex),
    .flush_if_id_ex_mem (flush_if_id_ex_mem),
    .freeze             (freeze),
    .busy_vec           (busy_vec)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic en, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic rw, logic mw, logic lop, logic [4:0] exrd, logic exmr, logic boj,
                              logic mb, logic wbv, logic [4:0] wbrd, logic [3:0] ctrl, logic [31:0] busy);
    vec_t v;
    v.nm = nm; v.en = en; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.mw = mw; v.lop = lop;
    v.exrd = exrd; v.exmr = exmr; v.boj = boj; v.mb = mb; v.wbv = wbv; v.wbrd = wbrd;
    v.exp_ctrl = ctrl; v.exp_busy = busy;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    enable = v.en; ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; ifid_rd = v.rd;
    ifid_reg_write = v.rw; ifid_mem_write = v.mw; ifid_long_op = v.lop;
    idex_rd = v.exrd; idex_mem_read = v.exmr; branch_or_jump = v.boj;
    mem_busy = v.mb; long_wb_valid = v.wbv; long_wb_rd = v.wbrd;
  endtask

  // Falling-edge checker: pops queued expectations; also flags writebacks to idle registers.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.nm, " ctrl"}, {28'd0, stall_n, flush_id_ex, flush_if_id_ex_mem, freeze}, {28'd0, e.exp_ctrl});
      chk({e.nm, " busy"}, busy_vec, e.exp_busy);
    end
    if (rst_n === 1'b1 && long_wb_valid === 1'b1) begin
      chk("wb_to_busy_reg", {31'd0, busy_vec[long_wb_rd]}, 32'd1);
    end
  end

  initial begin
    vec_t idle;
    idle = mk("idle", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0);
    //          name         en    rs1   rs2   rd    rw    mw    lop   exrd  exmr  boj   mb    wbv   wbrd  ctrl     busy
    vt.push_back(mk("idle0",  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("lu_b1",  1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h0));
    vt.push_back(mk("lu_b2",  1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h0));
    vt.push_back(mk("lu_end", 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("lu_st",  1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("iss7",   1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("raw7",   1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h80));
    vt.push_back(mk("raw7wb", 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 4'b0100, 32'h80));
    vt.push_back(mk("raw7ok", 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("iss3",   1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("waw3",   1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h8));
    vt.push_back(mk("waw3wb", 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 4'b0100, 32'h8));
    vt.push_back(mk("iss_x0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("x0_chk", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("pr_lu",  1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h0));
    vt.push_back(mk("pr_frz", 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 4'b0001, 32'h0));
    vt.push_back(mk("pr_fl",  1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b1110, 32'h0));
    vt.push_back(mk("pr_clr", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("hd_lu",  1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h0));
    vt.push_back(mk("hd_frz", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0001, 32'h0));
    vt.push_back(mk("hd_bub", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h0));
    vt.push_back(mk("hd_end", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("iss9",   1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("frz_wb", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 4'b0001, 32'h200));
    vt.push_back(mk("frz_hd", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0001, 32'h0));
    vt.push_back(mk("frz_no", 1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0001, 32'h0));
    vt.push_back(mk("en_lu",  1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h0));
    vt.push_back(mk("en_off", 1'b0, 5'd5, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("en_clr", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("iss11",  1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h0));
    vt.push_back(mk("fl_kp",  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b1110, 32'h800));
    vt.push_back(mk("fl_kp2", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h800));
    vt.push_back(mk("iss7b",  1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1000, 32'h800));
    vt.push_back(mk("pre_rs", 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100, 32'h880));

    rst_n = 1'b0;
    drive(idle);
    #3;
    chk("reset ctrl", {28'd0, stall_n, flush_id_ex, flush_if_id_ex_mem, freeze}, 32'h8);
    chk("reset busy", busy_vec, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vt[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      drive(vt[i]);
      e.nm = vt[i].nm; e.exp_ctrl = vt[i].exp_ctrl; e.exp_busy = vt[i].exp_busy;
      sbq.push_back(e);
    end

    // Asynchronous reset while bub_cnt=1 and busy_vec=0x880, checked before the next clock edge.
    @(posedge clk);
    #1 drive(idle);
    #1;
    chk("pre-reset ctrl", {28'd0, stall_n, flush_id_ex, flush_if_id_ex_mem, freeze}, 32'h4);
    chk("pre-reset busy", busy_vec, 32'h880);
    rst_n = 1'b0;
    #1;
    chk("async-reset ctrl", {28'd0, stall_n, flush_id_ex, flush_if_id_ex_mem, freeze}, 32'h8);
    chk("async-reset busy", busy_vec, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset ctrl", {28'd0, stall_n, flush_id_ex, flush_if_id_ex_mem, freeze}, 32'h8);
    chk("post-reset busy", busy_vec, 32'h0);

    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdu_scoreboard_ctrl.md
Name: hdu_scoreboard_ctrl

Overview:
Next-generation hazard detection unit for the 5-stage RV32I pipeline.
- Keeps the existing load-use and branch/jump flush behaviour.
- Generalises load-use to a configurable number of bubbles.
- Adds a per-register busy scoreboard for variable-latency units (mul/div) that stalls on RAW/WAW hazards.
- Adds a global freeze while data memory is busy.
- Sits in ID and drives the PC enable, the IF/ID enable and the flush muxes before IF/ID, ID/EX and EX/MEM.

Parameters:
RF_ADDR_WIDTH, 5, register-file address width.
NUM_REGS, 2**RF_ADDR_WIDTH, number of scoreboard entries; entry 0 is never set.
LOAD_BUBBLES, 1, bubbles inserted on a load-use hazard; legal range 1..7.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  hazard logic enable
ifid_rs1  in  RF_ADDR_WIDTH  source 1 of the instruction in ID
ifid_rs2  in  RF_ADDR_WIDTH  source 2 of the instruction in ID
ifid_rd  in  RF_ADDR_WIDTH  destination of the instruction in ID
ifid_reg_write  in  1  instruction in ID writes rd
ifid_mem_write  in  1  instruction in ID is a store
ifid_long_op  in  1  instruction in ID issues to a variable-latency unit
idex_rd  in  RF_ADDR_WIDTH  destination of the instruction in EX
idex_mem_read  in  1  instruction in EX is a load
branch_or_jump  in  1  taken branch or jump resolved in EX
mem_busy  in  1  data memory not ready this cycle
long_wb_valid  in  1  variable-latency unit writes back this cycle
long_wb_rd  in  RF_ADDR_WIDTH  destination of that writeback
stall_n  out  1  PC and IF/ID enable, active low
flush_id_ex  out  1  bubble or flush select for ID/EX
flush_if_id_ex_mem  out  1  flush select for IF/ID and EX/MEM
freeze  out  1  hold every pipeline register
busy_vec  out  NUM_REGS  current scoreboard state, for debug

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active low.
- Reset clears busy_vec to 0 and bub_cnt to 0. With that state the outputs are stall_n=1, flush_id_ex=0, flush_if_id_ex_mem=0, freeze=0.
- Outputs are combinational from the inputs and registered state. Latency is 0 cycles.
- Output priority, first match wins:
  1. !enable: normal operation, {stall_n,flush_id_ex,flush_if_id_ex_mem}=100, freeze=0.
  2. mem_busy: freeze=1, stall_n=0, both flushes 0. bub_cnt holds. The branch is re-presented after the freeze.
  3. branch_or_jump: 111. bub_cnt is cleared.
  4. bub_cnt!=0: 010, and bub_cnt decrements.
  5. load_use: 010, and bub_cnt loads LOAD_BUBBLES-1.
     - load_use = idex_mem_read && idex_rd!=0 && !ifid_mem_write && (idex_rd==ifid_rs1 || idex_rd==ifid_rs2).
  6. sb_hazard: 010.
     - sb_hazard = busy[ifid_rs1] || busy[ifid_rs2] || (ifid_reg_write && busy[ifid_rd]).
     - Index 0 always reads as not busy.
  7. Otherwise: 100.
- Scoreboard reads the registered busy bits only. There is no same-cycle bypass from long_wb, so a hazard on a register being written back this cycle costs one extra stall cycle.
- Issue condition: enable && ifid_long_op && ifid_reg_write && ifid_rd!=0 && result 100 && !freeze.
  - On issue, busy[ifid_rd] is set at the next edge.
- Writeback: long_wb_valid clears busy[long_wb_rd] at the next edge.
  - Writeback clears happen regardless of enable, freeze or flush.
  - Same-cycle set and clear of the same index: set wins. This only occurs via a WAW stall release, which is unreachable with rule 6, but the RTL still enforces it.
- A flush never clears busy bits, because in-flight long ops are older than the branch.
- long_wb_valid to a non-busy register is ignored. The bench flags it as an error.
- bub_cnt width is $clog2(LOAD_BUBBLES+1). No wrap is possible: decrement happens only when non-zero.
- enable=0 also clears bub_cnt.
- Asynchronous reset mid-stall or mid-freeze returns the block to the reset state immediately.

Decomposition:
- Add to rv32i_defs:
  - typedef hdu_ctrl_t as packed struct {stall_n, flush_id_ex, flush_if_id_ex_mem, freeze}.
  - localparams HDU_NORMAL=3'b100, HDU_BUBBLE=3'b010, HDU_FLUSH=3'b111.
- Sub-module hdu_busy_sb holds the busy register array, with set and clear ports, two read ports plus a WAW read port, and busy_vec out.
- The top level holds bub_cnt and the priority logic.

Test Plan:
1. Load-use, LOAD_BUBBLES=2: idex_mem_read=1, idex_rd=5, ifid_rs2=5 held → outputs 010 for exactly 2 cycles, then 100. Same stimulus with ifid_mem_write=1 → 100.
2. Long op: issue with ifid_rd=7. Next cycle ifid_rs1=7 → 010 each cycle. Pulse long_wb_valid with rd=7 → busy[7]=0 at the next edge, and 100 in the cycle after.
3. WAW and x0: busy[3]=1 with ifid_rd=3, ifid_reg_write=1 → 010. Issue with ifid_rd=0 → busy_vec stays 0.
4. Priority: mem_busy=1 together with branch_or_jump=1 and load_use → freeze=1, stall_n=0, flushes 0, bub_cnt unchanged. Drop mem_busy → 111, and bub_cnt cleared.
5. Writeback during freeze: busy[9]=1, mem_busy=1, long_wb_valid with rd=9 → busy[9]=0 next edge while freeze remains 1.
6. Reset: assert rst_n=0 asynchronously while bub_cnt=1 and busy_vec=0x0000_0880 → busy_vec=0, bub_cnt=0 and outputs 100, freeze=0 before the next clk edge.
